// File: rtl/line_trig_filt.sv
// Line-trigger glitch filter, edge detector, line-strobe divider and period monitor.
// Define LINE_TRIG_PERIOD_EN to build the period counter; otherwise PERIOD/PERIOD_VLD/OVF are tied to 0.
module line_trig_filt #(
    parameter int   FILT_W = 8,
    parameter int   DIV_W  = 8,
    parameter int   PER_W  = 24,
    parameter logic INIT   = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              DIN,
    input  logic              EN,
    input  logic [FILT_W-1:0] FILT_LEN,
    input  logic [DIV_W-1:0]  DIV,
    output logic              LEVEL,
    output logic              RISE,
    output logic              FALL,
    output logic              LINE_STB,
    output logic [PER_W-1:0]  PERIOD,
    output logic              PERIOD_VLD,
    output logic              OVF
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t            state;
    logic [FILT_W-1:0] fcnt;
    logic [DIV_W-1:0]  dcnt;

    // fcnt never passes FILT_LEN unless FILT_LEN shrinks, hence >= rather than ==.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fcnt  <= '0;
            LEVEL <= INIT;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            if (DIN == LEVEL) begin
                fcnt <= '0;
            end else if (fcnt >= FILT_LEN) begin
                LEVEL <= DIN;
                fcnt  <= '0;
                RISE  <= DIN;
                FALL  <= ~DIN;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

`ifdef LINE_TRIG_PERIOD_EN
    localparam logic [PER_W-1:0] PMAX = '1;
    logic [PER_W-1:0] pcnt;
`endif

    // EN low overrides everything, including a RISE on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            dcnt     <= '0;
            LINE_STB <= 1'b0;
`ifdef LINE_TRIG_PERIOD_EN
            pcnt       <= '0;
            PERIOD     <= '0;
            PERIOD_VLD <= 1'b0;
            OVF        <= 1'b0;
`endif
        end else begin
            LINE_STB <= 1'b0;
`ifdef LINE_TRIG_PERIOD_EN
            PERIOD_VLD <= 1'b0;
`endif
            if (!EN) begin
                state <= IDLE;
                dcnt  <= '0;
`ifdef LINE_TRIG_PERIOD_EN
                pcnt  <= '0;
`endif
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (RISE) begin
                            state    <= RUN;
                            LINE_STB <= 1'b1;
                            dcnt     <= (DIV == '0) ? '0 : DIV_W'(1);
`ifdef LINE_TRIG_PERIOD_EN
                            pcnt     <= PER_W'(1);
`endif
                        end
                    end
                    RUN: begin
                        if (RISE) begin
                            LINE_STB <= (dcnt == '0);
                            dcnt     <= (dcnt >= DIV) ? '0 : dcnt + 1'b1;
`ifdef LINE_TRIG_PERIOD_EN
                            PERIOD     <= pcnt;
                            OVF        <= (pcnt == PMAX);
                            PERIOD_VLD <= 1'b1;
                            pcnt       <= PER_W'(1);
                        end else if (pcnt != PMAX) begin
                            pcnt <= pcnt + 1'b1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef LINE_TRIG_PERIOD_EN
    assign PERIOD     = '0;
    assign PERIOD_VLD = 1'b0;
    assign OVF        = 1'b0;
`endif

endmodule

// File: tb/tb_line_trig_filt.sv
// Directed bench for line_trig_filt: filter table, then hand sequences for strobe, period, EN and reset.
module tb_line_trig_filt;
    localparam int PW = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          DIN = 1'b0;
    logic          EN = 1'b0;
    logic [7:0]    FILT_LEN = 8'd0;
    logic [7:0]    DIV = 8'd0;
    logic          LEVEL, RISE, FALL, LINE_STB, PERIOD_VLD, OVF;
    logic [PW-1:0] PERIOD;

    int n_chk = 0;
    int n_fail = 0;

    line_trig_filt #(.FILT_W(8), .DIV_W(8), .PER_W(PW), .INIT(1'b0)) dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .EN(EN), .FILT_LEN(FILT_LEN), .DIV(DIV),
        .LEVEL(LEVEL), .RISE(RISE), .FALL(FALL), .LINE_STB(LINE_STB),
        .PERIOD(PERIOD), .PERIOD_VLD(PERIOD_VLD), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       din;
        logic [7:0] flen;
        logic       level;
        logic       rise;
        logic       fall;
    } fvec_t;

    fvec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One DIN period of 'per' cycles (FILT_LEN must be 0): rise on edge 0, strobe/period on edge 1.
    task automatic wave(input int per, input logic stb, input logic vld, input int per_exp,
                        input logic ovf_exp, input string nm);
        int   stray;
        logic vld_e;
        int   pe;
        logic oe;
        stray = 0;
        vld_e = vld;
        pe    = per_exp;
        oe    = ovf_exp;
`ifndef LINE_TRIG_PERIOD_EN
        vld_e = 1'b0;
        pe    = 0;
        oe    = 1'b0;
`endif
        DIN = 1'b1;
        for (int i = 0; i < per; i++) begin
            if (i == per / 2) DIN = 1'b0;
            tick();
            if (i == 0) begin
                chk({nm, " rise"}, {30'd0, LEVEL, RISE}, 32'd3);
                if (LINE_STB || PERIOD_VLD) stray++;
            end else if (i == 1) begin
                chk({nm, " stb"}, {31'd0, LINE_STB}, {31'd0, stb});
                chk({nm, " vld"}, {31'd0, PERIOD_VLD}, {31'd0, vld_e});
                chk({nm, " period"}, {24'd0, PERIOD}, pe);
                chk({nm, " ovf"}, {31'd0, OVF}, {31'd0, oe});
            end else if (LINE_STB || PERIOD_VLD || RISE) begin
                stray++;
            end
        end
        chk({nm, " stray"}, stray, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 8'd1, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0};

        // Reset state
        #1;
        chk("reset outputs", {26'd0, LEVEL, RISE, FALL, LINE_STB, PERIOD_VLD, OVF}, 32'd0);
        chk("reset period", {24'd0, PERIOD}, 32'd0);
        #11 RST_N = 1'b1;
        tick();

        // Filter table, EN=0 so the FSM stays quiet
        foreach (tbl[k]) begin
            DIN = tbl[k].din;
            FILT_LEN = tbl[k].flen;
            tick();
            chk($sformatf("filt row %0d", k), {27'd0, LEVEL, RISE, FALL, LINE_STB, PERIOD_VLD},
                {27'd0, tbl[k].level, tbl[k].rise, tbl[k].fall, 2'b00});
        end

        FILT_LEN = 8'd0;
        DIN = 1'b0;
        tick();
        tick();
        EN = 1'b1;
        DIV = 8'd0;
        tick();
        tick();

        // Square wave, DIV=0
        wave(100, 1'b1, 1'b0, 0, 1'b0, "sq1");
        wave(100, 1'b1, 1'b1, 100, 1'b0, "sq2");
        wave(100, 1'b1, 1'b1, 100, 1'b0, "sq3");

        // Saturation then recovery
        wave(300, 1'b1, 1'b1, 100, 1'b0, "ovf1");
        wave(50, 1'b1, 1'b1, 255, 1'b1, "ovf2");
        wave(50, 1'b1, 1'b1, 50, 1'b0, "ovf3");
        wave(60, 1'b1, 1'b1, 50, 1'b0, "ovf4");

        // Divider: DIV=2 strobes on rises 1 and 4; switch to 0 with dcnt=2 wraps to strobe on rise 7
        DIV = 8'd2;
        wave(20, 1'b1, 1'b1, 60, 1'b0, "div r1");
        wave(20, 1'b0, 1'b1, 20, 1'b0, "div r2");
        wave(20, 1'b0, 1'b1, 20, 1'b0, "div r3");
        wave(20, 1'b1, 1'b1, 20, 1'b0, "div r4");
        wave(20, 1'b0, 1'b1, 20, 1'b0, "div r5");
        DIV = 8'd0;
        wave(20, 1'b0, 1'b1, 20, 1'b0, "div r6");
        wave(20, 1'b1, 1'b1, 20, 1'b0, "div r7");

        // EN dropped between rises
        EN = 1'b0;
        repeat (5) tick();
        EN = 1'b1;
        tick();
        tick();
        wave(30, 1'b1, 1'b0, 20, 1'b0, "reen1");
        wave(30, 1'b1, 1'b1, 30, 1'b0, "reen2");

        // EN falling on the RISE edge
        DIN = 1'b1;
        tick();
        chk("en-rise rise", {31'd0, RISE}, 32'd1);
        EN = 1'b0;
        tick();
        chk("en-rise no stb", {30'd0, LINE_STB, PERIOD_VLD}, 32'd0);
        DIN = 1'b0;
        repeat (3) tick();
        EN = 1'b1;
        tick();
        tick();
        wave(40, 1'b1, 1'b0, 30, 1'b0, "enr1");
        wave(40, 1'b1, 1'b1, 40, 1'b0, "enr2");

        // Async reset mid filter count and mid period
        DIN = 1'b1;
        tick();
        tick();
        FILT_LEN = 8'd5;
        DIN = 1'b0;
        tick();
        tick();
        #2 RST_N = 1'b0;
        #1;
        chk("async rst outputs", {26'd0, LEVEL, RISE, FALL, LINE_STB, PERIOD_VLD, OVF}, 32'd0);
        chk("async rst period", {24'd0, PERIOD}, 32'd0);
        RST_N = 1'b1;
        DIN = 1'b1;
        repeat (5) tick();
        chk("post-rst filt hold", {31'd0, LEVEL}, 32'd0);
        tick();
        chk("post-rst filt rise", {30'd0, LEVEL, RISE}, 32'd3);
        tick();
        chk("post-rst arm stb", {31'd0, LINE_STB}, 32'd1);
        chk("post-rst arm no vld", {31'd0, PERIOD_VLD}, 32'd0);
        chk("post-rst arm period", {24'd0, PERIOD}, 32'd0);
        DIN = 1'b0;
        FILT_LEN = 8'd0;
        tick();
        wave(40, 1'b1, 1'b1, 3, 1'b0, "prst1");
        wave(40, 1'b1, 1'b1, 40, 1'b0, "prst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/line_trig_filt.md
Name: line_trig_filt

Overview:
- Sits directly downstream of the 2-flop input synchronizer on the external line-trigger / encoder input.
- Consumes the already-synchronized level and applies a programmable glitch filter.
- Produces filtered level and edge pulses, plus a line strobe divided by a programmable ratio.
- Measures the trigger period in CLK cycles for the line-rate monitor.

Parameters:
FILT_W, 8, width of filter length input and filter counter
DIV_W, 8, width of divider input and divider counter
PER_W, 24, width of period counter/output
INIT, 1'b0, reset value of filtered level LEVEL

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; asynchronous assert, active-low
DIN  in  1  synchronized trigger level (from synchronizer DOUT)
EN  in  1  enables strobe generation and period measurement
FILT_LEN  in  FILT_W  filter length N; input must differ from LEVEL for N+1 consecutive edges
DIV  in  DIV_W  divide ratio; LINE_STB once every DIV+1 rising edges
LEVEL  out  1  filtered level
RISE  out  1  one-cycle pulse, LEVEL 0->1
FALL  out  1  one-cycle pulse, LEVEL 1->0
LINE_STB  out  1  one-cycle line strobe
PERIOD  out  PER_W  cycles between last two RISE pulses
PERIOD_VLD  out  1  one-cycle pulse, PERIOD updated
OVF  out  1  PERIOD saturated; valid with PERIOD_VLD, held until next update

Behaviour:
- Reset (RST_N=0, asynchronous):
  - LEVEL=INIT.
  - RISE, FALL, LINE_STB, PERIOD_VLD, OVF = 0; PERIOD=0.
  - All counters 0; FSM in IDLE.
- Filter (always active, independent of EN), evaluated every CLK edge:
  - DIN==LEVEL -> fcnt<=0.
  - DIN!=LEVEL and fcnt==FILT_LEN -> LEVEL<=DIN, fcnt<=0; RISE or FALL asserts on the same edge for one cycle.
  - DIN!=LEVEL otherwise -> fcnt<=fcnt+1.
  - Glitches of <=N cycles are rejected. FILT_LEN=0 gives 1-cycle latency DIN->LEVEL.
  - A FILT_LEN change mid-count applies immediately; fcnt>FILT_LEN counts as reaching it (compare >=).
- FSM states IDLE, ARM, RUN:
  - EN=0 in any state -> IDLE next edge: dcnt=0, pcnt=0, no LINE_STB/PERIOD_VLD. PERIOD/OVF hold their last values.
  - IDLE & EN=1 -> ARM.
  - ARM & RISE -> RUN: LINE_STB next cycle; dcnt<=(DIV==0)?0:1; pcnt<=1; no PERIOD_VLD.
  - RUN & RISE:
    - LINE_STB next cycle iff dcnt==0.
    - dcnt<=(dcnt>=DIV)?0:dcnt+1.
    - PERIOD<=pcnt, OVF<=(pcnt==all-ones), PERIOD_VLD next cycle, pcnt<=1.
  - RUN, no RISE -> pcnt<=pcnt+1, saturating at 2^PER_W-1.
- Latency:
  - LINE_STB and PERIOD_VLD assert exactly one cycle after RISE, together, and last one cycle.
  - PERIOD equals the cycle distance between consecutive RISE pulses.
- Simultaneous events:
  - EN falling on a RISE edge: IDLE wins; no strobe, no PERIOD update.
  - DIN toggling faster than the filter: no edges at all.
- Reset mid-operation returns everything to the reset values above. The first RISE after reset+EN only arms period measurement.

Optional Feature:
- Macro LINE_TRIG_PERIOD_EN.
- Defined: pcnt, PERIOD, PERIOD_VLD, OVF implemented as described.
- Undefined: period counter not built; PERIOD=0, PERIOD_VLD=0, OVF=0 constantly. Filter, FSM and LINE_STB behaviour are unchanged.

Test Plan:
- FILT_LEN=3, LEVEL=0; DIN high pulses of 3 and 4 cycles -> 3-cycle pulse ignored; 4-cycle pulse: LEVEL=1 and RISE on 4th high edge; FALL after 4 low cycles.
- FILT_LEN=0, DIV=0, EN=1, DIN square wave period 100 -> LINE_STB on every RISE+1; first rise gives no PERIOD_VLD; subsequent PERIOD=100, OVF=0.
- DIV=2 -> LINE_STB on rises 1, 4, 7; DIV changed 2->0 while dcnt=2 -> wraps, strobe on next rise.
- PER_W=8, rises 300 cycles apart -> PERIOD=255, OVF=1; then rises 50 apart -> PERIOD=50, OVF=0.
- EN dropped between rises, re-raised -> no PERIOD_VLD on the first rise after re-enable, LINE_STB on it; PERIOD holds across IDLE.
- RST_N asserted mid-filter count and mid-period -> outputs reset asynchronously; LEVEL=INIT; first RISE after release only arms.
- Macro undefined -> PERIOD/PERIOD_VLD/OVF stuck 0 through the square-wave test.
